// File: rtl/retrigger_pkg.sv
// Purpose: shared FSM encoding, synchroniser depth and default widths for the retrigger shaper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Imported by retrigger_chan and retrigger_shaper. The dead-time feature is
// selected at build time with the RETRIGGER_DEADTIME_EN macro.
package retrigger_pkg;

  // Per-channel FSM state. DEAD is only reachable when RETRIGGER_DEADTIME_EN
  // is defined; the encoding is kept identical in both builds.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DEAD   = 2'b10
  } rt_state_t;

  // Metastability stages ahead of the edge-detect register.
  localparam int SYNC_STAGES = 2;

  // Default parameter values for the shaper and its channels.
  localparam int DEF_WIDTH  = 48;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_DEAD_W = 4;

endpackage

// File: rtl/retrigger_chan.sv
// Purpose: one trigger channel - synchroniser, rising-edge detect, pulse stretcher FSM, optional dead-time.
// Latency: input edge to Q falling is 3 clk (+/-1 from asynchronous sampling); Q and busy are registered.
// Backpressure: none; hits arriving during DEAD, or during ACTIVE without retrigger, are dropped.
//
// Build option: RETRIGGER_DEADTIME_EN enables the DEAD state and dead counter;
// without it ACTIVE always returns to IDLE and i_dead_len is ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_pulse           raw asynchronous detector line (rising edge = hit)
//   i_act             channel enable; 0 forces IDLE with Q high
//   i_stretch_len     low-pulse length in cycles (0 behaves as 1), sampled on load
//   i_dead_len        dead-time after a pulse in cycles (0 = none), sampled on entry to DEAD
//   i_retrig_mode     1 = hit during the pulse reloads the length, sampled on load
//   o_q               shaped trigger, active low, idle high
//   o_busy            high while ACTIVE or DEAD
module retrigger_chan
  import retrigger_pkg::*;
#(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DEAD_W = DEF_DEAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pulse,
  input  logic              i_act,
  input  logic [LEN_W-1:0]  i_stretch_len,
  input  logic [DEAD_W-1:0] i_dead_len,
  input  logic              i_retrig_mode,
  output logic              o_q,
  output logic              o_busy
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // r_sync[0..SYNC_STAGES-1] are the synchroniser, r_sync[SYNC_STAGES] is the
  // edge-detect register.
  logic [SYNC_STAGES:0]   r_sync;
  // Fills with ones after reset; once the top bit is set, the last
  // synchroniser stage holds a real sample of the line rather than its
  // reset value.
  logic [SYNC_STAGES-1:0] r_fill;
  // Set once the line has been seen low after reset. A line held high across
  // reset release therefore never produces a hit, even though the
  // synchroniser resets to 0.
  logic                   r_armed;

  logic                   w_s2;
  logic                   w_s3;
  logic                   w_fill_done;
  logic                   w_hit;
  logic [LEN_W-1:0]       w_len_load;

  rt_state_t              r_state;
  logic [LEN_W-1:0]       r_len_cnt;
  logic                   r_retrig;
  logic                   r_q;
  logic                   r_busy;

`ifdef RETRIGGER_DEADTIME_EN
  localparam logic [DEAD_W-1:0] DEAD_ONE = {{(DEAD_W-1){1'b0}}, 1'b1};
  logic [DEAD_W-1:0]      r_dead_cnt;
`else
  // Dead-time length has no consumer in this build.
  logic                   w_unused_dead;
  assign w_unused_dead = ^i_dead_len;
`endif

  assign w_s2        = r_sync[SYNC_STAGES-1];
  assign w_s3        = r_sync[SYNC_STAGES];
  assign w_fill_done = r_fill[SYNC_STAGES-1];
  assign w_hit       = r_armed & w_s2 & ~w_s3;

  // Counter load value: max(stretch_len,1)-1, so the pulse lasts
  // max(stretch_len,1) cycles including the load cycle.
  assign w_len_load  = (i_stretch_len == '0) ? '0 : (i_stretch_len - LEN_ONE);

  // Synchroniser, edge-detect and arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-1:0], i_pulse};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      if (w_fill_done && !w_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Channel FSM with registered Q and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len_cnt  <= '0;
      r_retrig   <= 1'b0;
      r_q        <= 1'b1;
      r_busy     <= 1'b0;
`ifdef RETRIGGER_DEADTIME_EN
      r_dead_cnt <= '0;
`endif
    end else if (!i_act) begin
      // Disabling the channel aborts whatever it is doing.
      r_state    <= IDLE;
      r_len_cnt  <= '0;
      r_retrig   <= 1'b0;
      r_q        <= 1'b1;
      r_busy     <= 1'b0;
`ifdef RETRIGGER_DEADTIME_EN
      r_dead_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state   <= ACTIVE;
            r_len_cnt <= w_len_load;
            r_retrig  <= i_retrig_mode;
            r_q       <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        ACTIVE: begin
          // Reload takes priority over expiry so Q never blips high when a
          // retriggering hit lands on the last cycle.
          if (w_hit && r_retrig) begin
            r_len_cnt <= w_len_load;
            r_retrig  <= i_retrig_mode;
          end else if (r_len_cnt == '0) begin
            r_q <= 1'b1;
`ifdef RETRIGGER_DEADTIME_EN
            if (i_dead_len != '0) begin
              r_state    <= DEAD;
              r_dead_cnt <= i_dead_len - DEAD_ONE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_len_cnt <= r_len_cnt - LEN_ONE;
          end
        end

`ifdef RETRIGGER_DEADTIME_EN
        DEAD: begin
          // Hits are neither acted on nor remembered here.
          if (r_dead_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_dead_cnt <= r_dead_cnt - DEAD_ONE;
          end
        end
`endif

        default: begin
          r_state <= IDLE;
          r_q     <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_busy = r_busy;

endmodule

// File: rtl/retrigger_shaper.sv
// Purpose: WIDTH-channel trigger shaper; each asynchronous detector line becomes an active-low pulse.
// Latency: 3 clk from input rising edge to Q falling (+/-1 from asynchronous sampling).
// Backpressure: none; each channel drops hits it cannot accept (DEAD, or ACTIVE without retrigger).
//
// Build option: RETRIGGER_DEADTIME_EN enables per-channel dead-time after
// each pulse; otherwise i_dead_len is accepted but ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_pulse[WIDTH]    raw detector lines
//   i_act[WIDTH]      per-channel enable
//   i_stretch_len     shared pulse length (0 behaves as 1)
//   i_dead_len        shared dead-time length (0 = none)
//   i_retrig_mode     shared retrigger enable
//   o_q[WIDTH]        shaped triggers, active low, idle high
//   o_busy[WIDTH]     channel is ACTIVE or DEAD
module retrigger_shaper
  import retrigger_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DEAD_W = DEF_DEAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  i_pulse,
  input  logic [WIDTH-1:0]  i_act,
  input  logic [LEN_W-1:0]  i_stretch_len,
  input  logic [DEAD_W-1:0] i_dead_len,
  input  logic              i_retrig_mode,
  output logic [WIDTH-1:0]  o_q,
  output logic [WIDTH-1:0]  o_busy
);

  // Shared configuration fanned out to every channel. Each channel samples
  // these only when it loads a counter, so changes never disturb a pulse in
  // flight.
  logic [LEN_W-1:0]  w_stretch_len;
  logic [DEAD_W-1:0] w_dead_len;
  logic              w_retrig_mode;

  assign w_stretch_len = i_stretch_len;
  assign w_dead_len    = i_dead_len;
  assign w_retrig_mode = i_retrig_mode;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    retrigger_chan #(
      .LEN_W  (LEN_W),
      .DEAD_W (DEAD_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_pulse       (i_pulse[g]),
      .i_act         (i_act[g]),
      .i_stretch_len (w_stretch_len),
      .i_dead_len    (w_dead_len),
      .i_retrig_mode (w_retrig_mode),
      .o_q           (o_q[g]),
      .o_busy        (o_busy[g])
    );
  end

endmodule

// File: tb/tb_retrigger_shaper.sv
// Purpose: self-checking bench for retrigger_shaper against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_retrigger_shaper;

  localparam int W  = 48;
  localparam int LW = 4;
  localparam int DW = 4;
`ifdef RETRIGGER_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pulse;
  logic [W-1:0]  act;
  logic [LW-1:0] stretch;
  logic [DW-1:0] dead;
  logic          retrig;
  logic [W-1:0]  q;
  logic [W-1:0]  busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  retrigger_shaper #(.WIDTH(W), .LEN_W(LW), .DEAD_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pulse       (pulse),
    .i_act         (act),
    .i_stretch_len (stretch),
    .i_dead_len    (dead),
    .i_retrig_mode (retrig),
    .o_q           (q),
    .o_busy        (busy)
  );

  // Inputs as seen at each rising edge.
  logic [W-1:0]  s_pulse, s_act;
  logic [LW-1:0] s_stretch;
  logic [DW-1:0] s_dead;
  logic          s_retrig, s_rst;
  always @(posedge clk) begin
    s_pulse   <= pulse;
    s_act     <= act;
    s_stretch <= stretch;
    s_dead    <= dead;
    s_retrig  <= retrig;
    s_rst     <= rst_n;
  end

  // Behavioural model: remaining low cycles and remaining dead cycles per channel.
  int           rem_low[W];
  int           rem_dead[W];
  bit           lat_retrig[W];
  logic [W-1:0] h1, h2, h3;   // line samples from 1, 2, 3 edges ago
  int           nedge;
  logic [W-1:0] exp_q, exp_busy;

  // Run-length monitors for DUT and model.
  int d_run[W], d_last[W], d_fall[W], d_nfall[W];
  int m_run[W], m_last[W], m_nfall[W];

  task automatic model_reset();
    for (int c = 0; c < W; c++) begin
      rem_low[c] = 0; rem_dead[c] = 0; lat_retrig[c] = 1'b0;
    end
    h1 = '0; h2 = '0; h3 = '0; nedge = 0;
    exp_q = '1; exp_busy = '0;
  endtask

  task automatic model_step();
    int  n;
    bit  hit;
    nedge++;
    n = (s_stretch == '0) ? 1 : int'(s_stretch);
    for (int c = 0; c < W; c++) begin
      // A hit is a low-to-high transition between two real samples, seen two edges late.
      hit = (nedge >= 4) && h2[c] && !h3[c];
      if (!s_act[c]) begin
        rem_low[c] = 0; rem_dead[c] = 0;
      end else if (rem_low[c] > 0) begin
        if (hit && lat_retrig[c]) begin
          rem_low[c] = n; lat_retrig[c] = s_retrig;
        end else begin
          rem_low[c]--;
          if (rem_low[c] == 0 && DEAD_EN) rem_dead[c] = int'(s_dead);
        end
      end else if (rem_dead[c] > 0) begin
        rem_dead[c]--;
      end else if (hit) begin
        rem_low[c] = n; lat_retrig[c] = s_retrig;
      end
      exp_q[c]    = (rem_low[c] == 0);
      exp_busy[c] = (rem_low[c] > 0) || (rem_dead[c] > 0);
    end
    h3 = h2; h2 = h1; h1 = s_pulse;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Compare process: model advance, per-cycle comparison, run monitors.
  initial begin
    model_reset();
    for (int c = 0; c < W; c++) begin
      d_run[c] = 0; d_last[c] = 0; d_fall[c] = 0; d_nfall[c] = 0;
      m_run[c] = 0; m_last[c] = 0; m_nfall[c] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1 || s_rst !== 1'b1) model_reset();
      else model_step();
      checks += 2;
      if (q !== exp_q) begin
        errors++;
        $display("FAIL q cyc=%0d got %h expected %h", cyc, q, exp_q);
      end
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got %h expected %h", cyc, busy, exp_busy);
      end
      for (int c = 0; c < W; c++) begin
        if (q[c] === 1'b0) begin
          if (d_run[c] == 0) begin d_fall[c] = cyc; d_nfall[c]++; end
          d_run[c]++;
        end else begin
          if (d_run[c] > 0) d_last[c] = d_run[c];
          d_run[c] = 0;
        end
        if (exp_q[c] == 1'b0) begin
          if (m_run[c] == 0) m_nfall[c]++;
          m_run[c]++;
        end else begin
          if (m_run[c] > 0) m_last[c] = m_run[c];
          m_run[c] = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Bounded wait for q[ch] to reach v, sampled on falling edges.
  task automatic wait_q(input int ch, input logic v, input string name);
    int t;
    t = 0;
    while (q[ch] !== v && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk(name, (q[ch] === v) ? 1 : 0, 1);
  endtask

  initial begin
    int base, nf;
    rst_n = 1'b0; pulse = '0; act = '1; stretch = 4'd4; dead = '0; retrig = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_q_all_ones", (q === {W{1'b1}}) ? 1 : 0, 1);
    chk("reset_busy_zero", (busy === '0) ? 1 : 0, 1);
    rst_n = 1'b1;
    idle(6);

    // Single 20-unit pulse on ch 5. Rising 1 unit after an edge, the 4th
    // falling edge after the drive is the first to see Q low.
    @(posedge clk); #1; pulse[5] = 1'b1; base = cyc; #20; pulse[5] = 1'b0;
    idle(12);
    chk("t1_latency", d_fall[5] - base, 4);
    chk("t1_width", d_last[5], 4);
    chk("t1_model_width", m_last[5], 4);
    nf = 0;
    for (int c = 0; c < W; c++) if (c != 5) nf += d_nfall[c];
    chk("t1_other_quiet", nf, 0);

    // Second edge two cycles into the pulse, with and without retrigger.
    retrig = 1'b1;
    @(posedge clk); #1; pulse[5] = 1'b1; #12; pulse[5] = 1'b0; #10; pulse[5] = 1'b1; #15; pulse[5] = 1'b0;
    idle(12);
    chk("t2_retrig_width", d_last[5], 6);
    chk("t2_retrig_model_width", m_last[5], 6);
    retrig = 1'b0;
    nf = d_nfall[5];
    @(posedge clk); #1; pulse[5] = 1'b1; #12; pulse[5] = 1'b0; #10; pulse[5] = 1'b1; #15; pulse[5] = 1'b0;
    idle(12);
    chk("t2_noretrig_width", d_last[5], 4);
    chk("t2_noretrig_pulses", d_nfall[5] - nf, 1);

    // Behaviour right after a pulse ends.
    dead = 4'd3;
    @(posedge clk); #1; pulse[9] = 1'b1; #20; pulse[9] = 1'b0;
    wait_q(9, 1'b0, "t3_fall");
    chk("t3_busy_active", int'(busy[9]), 1);
    wait_q(9, 1'b1, "t3_rise");
    nf = d_nfall[9];
`ifdef RETRIGGER_DEADTIME_EN
    chk("t3_busy_dead0", int'(busy[9]), 1);
    #1; pulse[9] = 1'b1;
    @(negedge clk); chk("t3_busy_dead1", int'(busy[9]), 1);
    @(negedge clk); chk("t3_busy_dead2", int'(busy[9]), 1);
    @(negedge clk); chk("t3_busy_after_dead", int'(busy[9]), 0);
    pulse[9] = 1'b0;
    idle(6);
    chk("t3_dead_edge_ignored", d_nfall[9] - nf, 0);
    @(posedge clk); #1; pulse[9] = 1'b1; #20; pulse[9] = 1'b0;
    wait_q(9, 1'b0, "t3_fall2");
    wait_q(9, 1'b1, "t3_rise2");
    nf = d_nfall[9];
    repeat (3) @(negedge clk);
    #1; pulse[9] = 1'b1; #15; pulse[9] = 1'b0;
    idle(12);
    chk("t3_late_edge_pulses", d_nfall[9] - nf, 1);
    chk("t3_late_edge_width", d_last[9], 4);
    chk("t3_late_edge_model_width", m_last[9], 4);
`else
    chk("t3_busy_after_pulse", int'(busy[9]), 0);
    #1; pulse[9] = 1'b1; #15; pulse[9] = 1'b0;
    idle(12);
    chk("t3_immediate_edge_pulses", d_nfall[9] - nf, 1);
    chk("t3_immediate_edge_width", d_last[9], 4);
`endif
    dead = '0;

    // Zero length behaves as one cycle.
    stretch = '0;
    @(posedge clk); #1; pulse[11] = 1'b1; #20; pulse[11] = 1'b0;
    idle(8);
    chk("t4_zero_len_width", d_last[11], 1);
    chk("t4_zero_len_model_width", m_last[11], 1);

    // Channel disabled mid-pulse.
    stretch = 4'd8;
    @(posedge clk); #1; pulse[5] = 1'b1; #20; pulse[5] = 1'b0;
    wait_q(5, 1'b0, "t4_fall");
    @(negedge clk); @(negedge clk); #1; act[5] = 1'b0;
    @(negedge clk);
    chk("t4_act_drop_q", int'(q[5]), 1);
    chk("t4_act_drop_busy", int'(busy[5]), 0);
    act[5] = 1'b1;
    idle(4);

    // Reset mid-pulse, and a line held high across reset release.
    @(posedge clk); #1; pulse[5] = 1'b1; #20; pulse[5] = 1'b0;
    wait_q(5, 1'b0, "t5_fall");
    #2; rst_n = 1'b0; #1;
    chk("t5_async_reset_q", (q === {W{1'b1}}) ? 1 : 0, 1);
    chk("t5_async_reset_busy", (busy === '0) ? 1 : 0, 1);
    pulse[7] = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(12);
    chk("t5_held_high_no_pulse", d_nfall[7], 0);
    chk("t5_held_high_model", m_nfall[7], 0);
    pulse[7] = 1'b0;
    idle(6);

    // Channels 0 and 47, edges one sample period apart.
    stretch = 4'd4;
    @(posedge clk); #1; pulse[0] = 1'b1; #11; pulse[47] = 1'b1; #10; pulse[0] = 1'b0; #10; pulse[47] = 1'b0;
    idle(10);
    chk("t6_phase_offset", d_fall[47] - d_fall[0], 1);
    chk("t6_ch0_width", d_last[0], 4);
    chk("t6_ch47_width", d_last[47], 4);

    // Randomised traffic on all channels, checked against the model every cycle.
    for (int cy = 0; cy < 3000; cy++) begin
      @(posedge clk);
      #($urandom_range(1, 8));
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 4) == 0) pulse[c] = ~pulse[c];
      end
      if ($urandom_range(0, 39) == 0) begin
        base = $urandom_range(0, W - 1);
        act[base] = ~act[base];
      end
      if ($urandom_range(0, 59) == 0) act = '1;
      if ($urandom_range(0, 49) == 0) stretch = LW'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) dead = DW'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) retrig = ~retrig;
    end
    pulse = '0;
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
